// File: rtl/dice_pkg.sv
// Shared constants and types for the dice roller input side.
package dice_pkg;

   localparam int unsigned NUM_BUTTONS = 6;

   localparam logic [4:0] SIDES_D4  = 5'd4;
   localparam logic [4:0] SIDES_D6  = 5'd6;
   localparam logic [4:0] SIDES_D8  = 5'd8;
   localparam logic [4:0] SIDES_D10 = 5'd10;
   localparam logic [4:0] SIDES_D12 = 5'd12;
   localparam logic [4:0] SIDES_D20 = 5'd20;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RELEASE} state_e;

   // Smaller dice win when several presses land on the same cycle.
   function automatic logic [4:0] sides_for(input logic [NUM_BUTTONS-1:0] press);
      logic [4:0] sides;
      if (press[0])      sides = SIDES_D4;
      else if (press[1]) sides = SIDES_D6;
      else if (press[2]) sides = SIDES_D8;
      else if (press[3]) sides = SIDES_D10;
      else if (press[4]) sides = SIDES_D12;
      else if (press[5]) sides = SIDES_D20;
      else               sides = 5'd0;
      return sides;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus run-length debouncer for one raw input,
// with a one-cycle press pulse on each debounced rising edge.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             stable_d, stable_q;
   logic             prev_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         prev_q   <= stable_q;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;
   assign press  = stable_q & ~prev_q;

endmodule

// File: rtl/dice_button_rx.sv
// Turns debounced die-select presses into single roll requests over a
// valid/ready handshake; one request per press, no chording.
module dice_button_rx
   import dice_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       buttonD4,
   input  logic       buttonD6,
   input  logic       buttonD8,
   input  logic       buttonD10,
   input  logic       buttonD12,
   input  logic       buttonD20,
   input  logic       switchTest,
   output logic       roll_valid,
   output logic [4:0] roll_sides,
   output logic       roll_test,
   input  logic       roll_ready,
   output logic       busy
);

   localparam int unsigned NUM_IN = NUM_BUTTONS + 1;

   logic [NUM_IN-1:0] raw_vec, stable_vec, press_vec;
   logic              unused_test_press;

   assign raw_vec = {switchTest, buttonD20, buttonD12, buttonD10, buttonD8, buttonD6, buttonD4};

   for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
      button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_deb (
         .clk   (clk),
         .reset (reset),
         .raw   (raw_vec[i]),
         .stable(stable_vec[i]),
         .press (press_vec[i])
      );
   end

   // The test switch is level-only; its edge pulse has no consumer.
   assign unused_test_press = press_vec[NUM_IN-1];

   state_e     state_d, state_q;
   logic       valid_d, valid_q;
   logic [4:0] sides_d, sides_q;
   logic       test_d, test_q;
   logic       busy_d, busy_q;

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      sides_d = sides_q;
      test_d  = test_q;
      busy_d  = busy_q;
      unique case (state_q)
         IDLE: begin
            if (|press_vec[NUM_BUTTONS-1:0]) begin
               state_d = REQ;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               sides_d = sides_for(press_vec[NUM_BUTTONS-1:0]);
               test_d  = stable_vec[NUM_IN-1];
            end
         end
         REQ: begin
            if (roll_ready) begin
               state_d = WAIT_RELEASE;
               valid_d = 1'b0;
            end
         end
         WAIT_RELEASE: begin
            if (stable_vec[NUM_BUTTONS-1:0] == '0) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         sides_q <= 5'd0;
         test_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         sides_q <= sides_d;
         test_q  <= test_d;
         busy_q  <= busy_d;
      end
   end

   assign roll_valid = valid_q;
   assign roll_sides = sides_q;
   assign roll_test  = test_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_dice_button_rx.sv
// Bench for dice_button_rx: behavioural model feeds an expectation queue,
// an independent monitor checks every cycle and every request.
module tb_dice_button_rx;

   localparam int D = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] btn;
   logic       sw;
   logic       roll_ready;
   logic       roll_valid;
   logic [4:0] roll_sides;
   logic       roll_test;
   logic       busy;

   always #5 clk = ~clk;

   dice_button_rx #(.DEBOUNCE_CYCLES(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .buttonD4  (btn[0]),
      .buttonD6  (btn[1]),
      .buttonD8  (btn[2]),
      .buttonD10 (btn[3]),
      .buttonD12 (btn[4]),
      .buttonD20 (btn[5]),
      .switchTest(sw),
      .roll_valid(roll_valid),
      .roll_sides(roll_sides),
      .roll_test (roll_test),
      .roll_ready(roll_ready),
      .busy      (busy)
   );

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;

   typedef struct {
      int sides;
      int test;
   } req_t;

   req_t exp_q[$];
   req_t cur;
   int   sides_tab[6] = '{4, 6, 8, 10, 12, 20};

   // Reference model state: synchronized samples, debounced levels, run lengths.
   bit [6:0] m_s1, m_s2, m_stable, m_prev;
   int       m_run[7];
   bit       m_pending, m_waiting;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0;
      for (int i = 0; i < 7; i++) m_run[i] = 0;
      m_pending = 1'b0;
      m_waiting = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_step();
      bit [6:0] raw;
      int       pick;
      req_t     r;
      raw = {sw, btn};
      if (reset) begin
         model_reset();
         return;
      end
      if (!m_pending && !m_waiting) begin
         pick = -1;
         for (int i = 5; i >= 0; i--) if (m_stable[i] && !m_prev[i]) pick = i;
         if (pick >= 0) begin
            m_pending = 1'b1;
            r.sides   = sides_tab[pick];
            r.test    = int'(m_stable[6]);
            exp_q.push_back(r);
         end
      end else if (m_pending) begin
         if (roll_ready) begin
            m_pending = 1'b0;
            m_waiting = 1'b1;
         end
      end else if (m_stable[5:0] == 6'd0) begin
         m_waiting = 1'b0;
      end
      for (int i = 0; i < 7; i++) begin
         m_prev[i] = m_stable[i];
         if (m_s2[i] != m_stable[i]) begin
            m_run[i]++;
            if (m_run[i] == D) begin
               m_stable[i] = m_s2[i];
               m_run[i]    = 0;
            end
         end else begin
            m_run[i] = 0;
         end
         m_s2[i] = m_s1[i];
         m_s1[i] = raw[i];
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         cyc++;
         model_step();
      end
   end

   // Monitor: compares DUT against model each cycle, pops a request on each rise.
   initial begin
      bit last_valid;
      last_valid = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            last_valid = 1'b0;
         end else begin
            chk("roll_valid", int'(roll_valid), int'(m_pending));
            chk("busy", int'(busy), int'(m_pending | m_waiting));
            if (roll_valid && !last_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_request", 1, 0);
               end else begin
                  cur = exp_q.pop_front();
                  chk("roll_sides", int'(roll_sides), cur.sides);
                  chk("roll_test", int'(roll_test), cur.test);
               end
            end else if (roll_valid) begin
               chk("roll_sides_hold", int'(roll_sides), cur.sides);
               chk("roll_test_hold", int'(roll_test), cur.test);
            end
            last_valid = roll_valid;
         end
      end
   end

   task automatic do_reset(input logic sw_val);
      @(negedge clk);
      reset = 1'b1;
      sw    = sw_val;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   // Counts rising edges until roll_valid is seen; flags a timeout.
   task automatic wait_valid(input string name, output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (!roll_valid && n < 200);
      chk(name, int'(roll_valid), 1);
   endtask

   initial begin
      int n;
      reset      = 1'b1;
      btn        = '0;
      sw         = 1'b0;
      roll_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_valid", int'(roll_valid), 0);
      chk("reset_sides", int'(roll_sides), 0);
      chk("reset_test", int'(roll_test), 0);
      chk("reset_busy", int'(busy), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // D6 held with ready high: one pulse after 19 edges, none while held.
      roll_ready = 1'b1;
      btn[1]     = 1'b1;
      wait_valid("d6_timeout", n);
      chk("d6_latency", n, D + 3);
      chk("d6_sides", int'(roll_sides), 6);
      @(posedge clk);
      #1;
      chk("d6_pulse_width", int'(roll_valid), 0);
      repeat (40) @(negedge clk);
      btn[1] = 1'b0;
      repeat (25) @(negedge clk);

      // Short glitch never becomes a request (monitor checks roll_valid).
      btn[2] = 1'b1;
      repeat (10) @(negedge clk);
      btn[2] = 1'b0;
      repeat (40) @(negedge clk);
      chk("glitch_idle", int'(busy), 0);

      // Simultaneous D20 and D4 with test switch on since reset.
      do_reset(1'b1);
      repeat (3) @(negedge clk);
      btn[5] = 1'b1;
      btn[0] = 1'b1;
      wait_valid("chord_timeout", n);
      chk("chord_sides", int'(roll_sides), 4);
      chk("chord_test", int'(roll_test), 1);
      @(negedge clk);
      btn = '0;
      sw  = 1'b0;
      repeat (30) @(negedge clk);

      // D10 waits 50 cycles for ready; D12 during the wait is ignored.
      roll_ready = 1'b0;
      btn[3]     = 1'b1;
      wait_valid("stall_timeout", n);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (i == 10) btn[4] = 1'b1;
      end
      chk("stall_valid", int'(roll_valid), 1);
      chk("stall_sides", int'(roll_sides), 10);
      roll_ready = 1'b1;
      @(negedge clk);
      chk("stall_xfer", int'(roll_valid), 0);
      repeat (5) @(negedge clk);
      btn = '0;
      repeat (30) @(negedge clk);

      // D12 held through handshake, released, re-pressed after release settles.
      btn[4] = 1'b1;
      wait_valid("d12_timeout", n);
      repeat (30) @(negedge clk);
      btn[4] = 1'b0;
      repeat (5) @(negedge clk);
      chk("d12_busy_release", int'(busy), 1);
      repeat (30) @(negedge clk);
      chk("d12_idle", int'(busy), 0);
      btn[4] = 1'b1;
      wait_valid("d12_repress_timeout", n);
      chk("d12_repress_sides", int'(roll_sides), 12);
      @(negedge clk);
      btn[4] = 1'b0;
      repeat (30) @(negedge clk);

      // Reset during REQ drops the request at once; held button re-requests.
      roll_ready = 1'b0;
      btn[2]     = 1'b1;
      wait_valid("rst_timeout", n);
      @(negedge clk);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("rst_async_valid", int'(roll_valid), 0);
      chk("rst_async_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      roll_ready = 1'b1;
      reset      = 1'b0;
      wait_valid("rst_again_timeout", n);
      chk("rst_again_latency", n, D + 3);
      chk("rst_again_sides", int'(roll_sides), 8);
      @(negedge clk);
      btn = '0;
      repeat (30) @(negedge clk);

      // Randomized button activity checked against the model.
      for (int seg = 0; seg < 80; seg++) begin
         int       kind, dur;
         bit [5:0] mask;
         kind = int'($urandom_range(0, 9));
         dur  = int'($urandom_range(1, 50));
         if (kind <= 5)      mask = 6'(1 << kind);
         else if (kind == 6) mask = 6'((1 << $urandom_range(0, 5)) | (1 << $urandom_range(0, 5)));
         else if (kind == 7) mask = 6'd0;
         else if (kind == 8) begin
            mask = 6'(1 << $urandom_range(0, 5));
            dur  = int'($urandom_range(1, 12));
         end else mask = 6'h3f;
         if ($urandom_range(0, 4) == 0) sw = ~sw;
         btn = mask;
         for (int c = 0; c < dur; c++) begin
            roll_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
         end
      end

      btn        = '0;
      roll_ready = 1'b1;
      repeat (60) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      chk("final_busy", int'(busy), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
